// File: rtl/i_type_decode_ctrl.sv
// i_type_decode_ctrl: decode-stage controller for I-type instructions
// (OP-IMM, LOAD, JALR) with a small FIFO between fetch and rename.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush           drop all buffered entries, block input this cycle
//   in_valid/ready  fetch handshake (in_ready = !full && !flush)
//   in_instr, in_pc raw instruction word and its PC
//   out_valid/ready rename handshake on the registered FIFO head
//   out_*           decoded fields of the head entry (zero when empty)
//   itype_count     legal I-type instructions handed to rename
module i_type_decode_ctrl #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_func3,
  output logic [4:0]       out_rs1,
  output logic [31:0]      out_imm,
  output logic             out_is_itype,
  output logic             out_illegal,
  output logic [CNT_W-1:0] itype_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  func3;
    logic [4:0]  rs1;
    logic [31:0] imm;
    logic        is_itype;
    logic        illegal;
  } dec_t;

  dec_t          mem [DEPTH];
  dec_t          wdec;
  dec_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          legal_pop;

  logic          is_imm;
  logic          is_load;
  logic          is_jalr;
  logic [2:0]    f3;
  logic [6:0]    f7;

  // Decode at write time so the FIFO head is a plain register read.
  assign is_imm  = (in_instr[6:0] == OP_IMM);
  assign is_load = (in_instr[6:0] == OP_LOAD);
  assign is_jalr = (in_instr[6:0] == OP_JALR);
  assign f3      = in_instr[14:12];
  assign f7      = in_instr[31:25];

  always_comb begin
    wdec          = '0;
    wdec.pc       = in_pc;
    wdec.opcode   = in_instr[6:0];
    wdec.rd       = in_instr[11:7];
    wdec.func3    = f3;
    wdec.rs1      = in_instr[19:15];
    wdec.imm      = {{20{in_instr[31]}},
                     in_instr[31:20]};
    wdec.is_itype = is_imm | is_load | is_jalr;
    unique case (1'b1)
      is_jalr:
        wdec.illegal = (f3 != 3'b000);
      is_load:
        wdec.illegal = (f3 == 3'b011) ||
                       (f3 == 3'b110) ||
                       (f3 == 3'b111);
      is_imm && (f3 == 3'b001):
        wdec.illegal = (f7 != 7'b0000000);
      is_imm && (f3 == 3'b101):
        wdec.illegal = (f7 != 7'b0000000) &&
                       (f7 != 7'b0100000);
      default:
        wdec.illegal = 1'b0;
    endcase
  end

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full && !flush;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  // A flush discards the head, so its pop never counts.
  assign pop       = out_valid && out_ready && !flush;
  assign head      = mem[rd_ptr];
  assign legal_pop = pop && head.is_itype &&
                     !head.illegal;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      itype_count <= '0;
    end else if (legal_pop) begin
      itype_count <= itype_count + 1'b1;
    end
  end

  assign out_pc       = out_valid ? head.pc     : '0;
  assign out_opcode   = out_valid ? head.opcode : '0;
  assign out_rd       = out_valid ? head.rd     : '0;
  assign out_func3    = out_valid ? head.func3  : '0;
  assign out_rs1      = out_valid ? head.rs1    : '0;
  assign out_imm      = out_valid ? head.imm    : '0;
  assign out_is_itype = out_valid && head.is_itype;
  assign out_illegal  = out_valid && head.illegal;

endmodule

// File: tb/tb_i_type_decode_ctrl.sv
// tb_i_type_decode_ctrl: scoreboard bench for i_type_decode_ctrl
// with directed cases followed by randomized traffic.
module tb_i_type_decode_ctrl;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [2:0]  out_func3;
  logic [4:0]  out_rs1;
  logic [31:0] out_imm;
  logic        out_is_itype;
  logic        out_illegal;
  logic [31:0] itype_count;

  always #5 clk = ~clk;

  i_type_decode_ctrl #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode),
    .out_rd(out_rd), .out_func3(out_func3),
    .out_rs1(out_rs1), .out_imm(out_imm),
    .out_is_itype(out_is_itype),
    .out_illegal(out_illegal),
    .itype_count(itype_count)
  );

  typedef struct {
    bit [31:0] pc;
    int        opcode;
    int        rd;
    int        func3;
    int        rs1;
    bit [31:0] imm;
    bit        itype;
    bit        illegal;
  } exp_t;

  exp_t      sb[$];
  exp_t      mh;
  exp_t      pend_e;
  bit        pend_push = 0;
  bit        pend_clr  = 0;
  bit        go        = 0;
  bit [31:0] exp_cnt   = 0;
  int        nchk      = 0;
  int        nfail     = 0;

  // Reference decode straight from the instruction-set rules.
  function automatic exp_t model(bit [31:0] ins, bit [31:0] pc);
    exp_t e;
    int   f7;
    e.pc     = pc;
    e.opcode = int'(ins % 128);
    e.rd     = int'((ins / 128) % 32);
    e.func3  = int'((ins / 4096) % 8);
    e.rs1    = int'((ins / 32768) % 32);
    e.imm    = 32'($signed(ins) >>> 20);
    f7       = int'(ins / 33554432);
    e.itype  = e.opcode inside {'h13, 'h03, 'h67};
    e.illegal = 0;
    if (e.opcode == 'h67)
      e.illegal = (e.func3 != 0);
    else if (e.opcode == 'h03)
      e.illegal = e.func3 inside {3, 6, 7};
    else if (e.opcode == 'h13 && e.func3 == 1)
      e.illegal = (f7 != 0);
    else if (e.opcode == 'h13 && e.func3 == 5)
      e.illegal = !(f7 inside {0, 'h20});
    return e;
  endfunction

  task automatic chk(string n, logic [31:0] got, logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", n, got, want);
    end
  endtask

  // Monitor: compares the head whenever the model holds an entry.
  always @(negedge clk) begin
    if (go) begin
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      chk("itype_count", itype_count, exp_cnt);
      if (sb.size() != 0) begin
        mh = sb[0];
        if (out_valid) begin
          chk("out_pc", out_pc, mh.pc);
          chk("out_opcode", 32'(out_opcode), 32'(mh.opcode));
          chk("out_rd", 32'(out_rd), 32'(mh.rd));
          chk("out_func3", 32'(out_func3), 32'(mh.func3));
          chk("out_rs1", 32'(out_rs1), 32'(mh.rs1));
          chk("out_imm", out_imm, mh.imm);
          chk("out_is_itype", 32'(out_is_itype), 32'(mh.itype));
          chk("out_illegal", 32'(out_illegal), 32'(mh.illegal));
        end
        if (out_ready && !flush && !rst) begin
          void'(sb.pop_front());
          if (mh.itype && !mh.illegal) exp_cnt++;
        end
      end else begin
        chk("out_pc_idle", out_pc, 32'h0);
        chk("out_imm_idle", out_imm, 32'h0);
      end
      if (rst) exp_cnt = 0;
    end
  end

  // One cycle of stimulus; the accepted entry joins the model at the edge.
  task automatic step(bit r, bit f, bit v, bit [31:0] ins,
                      bit [31:0] pc, bit rdy);
    bit exp_rdy;
    @(posedge clk);
    if (pend_clr) sb.delete();
    else if (pend_push) sb.push_back(pend_e);
    #1;
    rst       = r;
    flush     = f;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    #1;
    exp_rdy = !f && (sb.size() < DEPTH);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    pend_clr  = r || f;
    pend_push = v && exp_rdy;
    pend_e    = model(ins, pc);
  endtask

  task automatic idle(bit rdy);
    step(0, 0, 0, 32'h0, 32'h0, rdy);
  endtask

  function automatic bit [31:0] rnd_instr();
    bit [31:0] w;
    bit [6:0]  ops [4];
    int        k;
    ops = '{7'h13, 7'h03, 7'h67, 7'h33};
    w   = $urandom();
    k   = $urandom_range(0, 4);
    if (k < 4) w[6:0] = ops[k];
    case ($urandom_range(0, 2))
      0:       w[31:25] = 7'h00;
      1:       w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  localparam bit [31:0] ADDI = 32'hFFF00093;
  localparam bit [31:0] SRAI = 32'h40335293;
  localparam bit [31:0] SLLX = 32'h40009093;
  localparam bit [31:0] JALX = 32'h000010E7;
  localparam bit [31:0] ADDR = 32'h00000033;

  bit [31:0] rpc;

  initial begin
    rst = 1; flush = 0; in_valid = 0;
    in_instr = 0; in_pc = 0; out_ready = 0;
    step(1, 0, 0, 0, 0, 0);
    go = 1;
    step(1, 0, 0, 0, 0, 0);
    idle(1);

    step(0, 0, 1, ADDI, 32'h100, 1);
    idle(1); idle(1);
    step(0, 0, 1, SRAI, 32'h104, 1);
    idle(1);
    step(0, 0, 1, SLLX, 32'h108, 1);
    idle(1);
    step(0, 0, 1, JALX, 32'h10c, 1);
    idle(1);
    step(0, 0, 1, ADDR, 32'h110, 1);
    idle(1); idle(1);

    step(0, 0, 1, ADDI, 32'h200, 0);
    step(0, 0, 1, ADDI, 32'h204, 0);
    step(0, 0, 1, ADDI, 32'h208, 0);
    idle(1);
    idle(0);
    idle(1); idle(1);

    step(0, 0, 1, ADDI, 32'h300, 0);
    step(0, 0, 1, ADDI, 32'h304, 0);
    step(0, 1, 1, ADDI, 32'h308, 1);
    idle(0);
    step(0, 0, 1, SRAI, 32'h30c, 1);
    idle(1); idle(0);

    step(0, 0, 1, ADDI, 32'h310, 0);
    idle(0);
    step(1, 0, 1, ADDI, 32'h314, 1);
    idle(1); idle(1);

    rpc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0,
           rnd_instr(), rpc,
           $urandom_range(0, 2) != 0);
      rpc += 4;
    end

    for (int i = 0; i < 4; i++) idle(1);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
